// File: rtl/stream_accum_pe.sv
// rtl/stream_accum_pe.sv - lane-wise block accumulator between a read stream and a write stream
// Sums each signed lane over BLOCK_LEN words and queues one result word per block.
module stream_accum_pe #(
    parameter int DATA_WIDTH = 128,
    parameter int LANE_WIDTH = 32,
    parameter int BLOCK_LEN  = 16,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           num_blocks,
    output logic                  rd,
    input  logic                  vld,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  wr,
    input  logic                  full,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           blocks_out
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int CW    = $clog2(BLOCK_LEN + 1);
    localparam int PW    = $clog2(OUT_DEPTH);
    localparam int NW    = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [31:0]           req_left;
    logic [CW-1:0]         word_in_blk;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] lane_sum;
    logic [DATA_WIDTH-1:0] fifo_mem [OUT_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [NW-1:0]         fifo_count;
    logic                  inflight;
    logic                  accept;
    logic                  push;
    logic                  pop;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i*LANE_WIDTH +: LANE_WIDTH] = acc[i*LANE_WIDTH +: LANE_WIDTH]
                                                 + dout[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    assign accept = vld && (state != IDLE);
    assign push   = accept && (word_in_blk == CW'(BLOCK_LEN - 1));
    assign pop    = wr;

    // Holding one slot free absorbs the single word still in flight after rd drops.
    assign rd  = (state == RUN) && (req_left != 32'd0) && (fifo_count < NW'(OUT_DEPTH - 1));
    assign wr  = (fifo_count != '0) && !full;
    assign din = (fifo_count != '0) ? fifo_mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= lane_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_left    <= '0;
            word_in_blk <= '0;
            acc         <= '0;
            wptr        <= '0;
            rptr        <= '0;
            fifo_count  <= '0;
            inflight    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            blocks_out  <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= rd;

            if (accept) begin
                if (push) begin
                    acc         <= '0;
                    word_in_blk <= '0;
                end else begin
                    acc         <= lane_sum;
                    word_in_blk <= word_in_blk + CW'(1);
                end
            end

            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (pop) blocks_out <= blocks_out + 32'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_blocks != 32'd0) begin
                            req_left    <= num_blocks * 32'(BLOCK_LEN);
                            acc         <= '0;
                            word_in_blk <= '0;
                            blocks_out  <= '0;
                            busy        <= 1'b1;
                            state       <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd) req_left <= req_left - 32'd1;
                    if (req_left == 32'd0 || (rd && req_left == 32'd1)) state <= DRAIN;
                end
                DRAIN: begin
                    // inflight marks the cycle the last requested word returns
                    if (!inflight && fifo_count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == NW'(OUT_DEPTH)));

endmodule

// File: tb/tb_stream_accum_pe.sv
// tb/tb_stream_accum_pe.sv - self-checking bench for stream_accum_pe
module tb_stream_accum_pe;
    localparam int DW    = 128;
    localparam int LW    = 32;
    localparam int BL    = 4;
    localparam int OD    = 4;
    localparam int LANES = DW / LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   num_blocks;
    logic          rd;
    logic          vld;
    logic [DW-1:0] dout;
    logic          wr;
    logic          full;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic [31:0]   blocks_out;

    stream_accum_pe #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .BLOCK_LEN(BL), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
        .rd(rd), .vld(vld), .dout(dout), .wr(wr), .full(full), .din(din),
        .busy(busy), .done(done), .blocks_out(blocks_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]           nb;
        logic [BL-1:0][DW-1:0] words;
        logic [DW-1:0]         exp;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int            served   = 0;
    int            done_cnt = 0;
    int            wr_cnt   = 0;
    int            rd_cnt   = 0;
    bit            full_hold = 1'b0;
    bit            full_rand = 1'b0;
    vec_t          tv[4];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkw(input logic [31:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LW +: LW] = $urandom;
        return r;
    endfunction

    // Reference: each result lane is the sum of that lane over the block, modulo 2^LW.
    task automatic queue_block(input logic [BL-1:0][DW-1:0] blk);
        logic [DW-1:0] r;
        logic [LW-1:0] s;
        for (int i = 0; i < LANES; i++) begin
            s = '0;
            for (int j = 0; j < BL; j++) s = s + blk[j][i*LW +: LW];
            r[i*LW +: LW] = s;
        end
        for (int j = 0; j < BL; j++) src_q.push_back(blk[j]);
        exp_q.push_back(r);
    endtask

    task automatic queue_random(input int n);
        logic [BL-1:0][DW-1:0] blk;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < BL; j++) blk[j] = rand_word();
            queue_block(blk);
        end
    endtask

    task automatic start_job(input logic [31:0] nb);
        @(posedge clk); #1;
        num_blocks = nb;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [31:0] nb);
        int base;
        int cyc;
        base = done_cnt;
        start_job(nb);
        cyc = 0;
        while (done_cnt == base && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - base, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_blocks_out"}, blocks_out, nb);
        check({tag, "_results_left"}, exp_q.size(), 0);
        check({tag, "_words_left"}, src_q.size(), 0);
    endtask

    // Read-stream responder: vld follows an accepted rd by exactly one cycle.
    initial begin
        logic rd_s;
        vld  = 1'b0;
        dout = '0;
        forever begin
            @(negedge clk);
            rd_s = rd;
            @(posedge clk); #1;
            vld = rd_s;
            if (rd_s) begin
                served++;
                dout = (src_q.size() != 0) ? src_q.pop_front() : rand_word();
            end else begin
                dout = rand_word();
            end
        end
    end

    initial begin
        full = 1'b0;
        forever begin
            @(posedge clk); #1;
            full = full_hold || (full_rand && ($urandom_range(0, 2) == 0));
        end
    end

    // Write-side monitor: results must arrive in order and never while full.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rd) rd_cnt++;
            if (full) check("wr_while_full", wr, 0);
            if (wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wr: din %0h with no result expected", din);
                end else begin
                    check("din", din, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int base;
        int rd0;
        int wr0;
        int cyc;

        tv[0].nb    = 1;
        tv[0].words = {4{mkw(4, 3, 2, 1)}};
        tv[0].exp   = mkw(16, 12, 8, 4);
        tv[1].nb    = 1;
        tv[1].words = {mkw(0, 0, 5, 0), mkw(0, 0, 5, 0), mkw(0, 0, 5, 1), mkw(0, 0, 5, 32'h7FFFFFFF)};
        tv[1].exp   = mkw(0, 0, 20, 32'h80000000);
        tv[2].nb    = 2;
        tv[2].words = {4{mkw(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF)}};
        tv[2].exp   = mkw(32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC);
        tv[3].nb    = 3;
        tv[3].words = {mkw(32'h80000000, 32'hFFFFFFFF, 40, 2),
                       mkw(32'h80000000, 1, 30, 0),
                       mkw(32'h80000000, 32'hFFFFFFFF, 20, 0),
                       mkw(32'h80000000, 1, 10, 32'hFFFFFFFF)};
        tv[3].exp   = mkw(0, 0, 100, 1);

        rst        = 1'b1;
        start      = 1'b0;
        num_blocks = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rd", rd, 0);
        check("reset_wr", wr, 0);
        check("reset_din", din, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_blocks_out", blocks_out, 0);

        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < tv[k].nb; b++) begin
                for (int j = 0; j < BL; j++) src_q.push_back(tv[k].words[j]);
                exp_q.push_back(tv[k].exp);
            end
            run_job($sformatf("vec%0d", k), tv[k].nb);
        end

        base = done_cnt;
        rd0  = rd_cnt;
        wr0  = wr_cnt;
        start_job(0);
        @(negedge clk);
        check("zero_done_pulse", done, 1);
        check("zero_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("zero_done_once", done_cnt - base, 1);
        check("zero_no_rd", rd_cnt - rd0, 0);
        check("zero_no_wr", wr_cnt - wr0, 0);
        check("zero_busy_after", busy, 0);

        full_hold = 1'b1;
        queue_random(8);
        s0 = served;
        start_job(8);
        repeat (50) @(negedge clk);
        check("full_rd_words", served - s0, (OD - 1) * BL + 1);
        check("full_rd_stopped", rd, 0);
        check("full_no_wr_yet", exp_q.size(), 8);
        full_hold = 1'b0;
        run_job("full_release", 8);

        queue_random(32);
        run_job("rand32", 32);

        full_rand = 1'b1;
        queue_random(10);
        run_job("rand_bp", 10);
        full_rand = 1'b0;

        full_hold = 1'b1;
        queue_random(4);
        s0   = served;
        base = done_cnt;
        start_job(4);
        cyc = 0;
        while (served - s0 < 2 * BL && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_setup_words", served - s0 >= 2 * BL, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        full_hold = 1'b0;
        @(negedge clk);
        check("rst_mid_rd", rd, 0);
        check("rst_mid_wr", wr, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_blocks_out", blocks_out, 0);
        check("rst_mid_din", din, 0);
        repeat (6) @(negedge clk);
        check("rst_mid_no_done", done_cnt - base, 0);
        check("rst_mid_no_wr", wr, 0);
        src_q.delete();
        exp_q.delete();
        queue_random(2);
        run_job("after_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
